// File: rtl/q_4phase_rx.sv
// 4-phase request/acknowledge receiver: synchronises req, captures bundled data into a FWFT FIFO.
// Optional Q4RX_STALL_CNT_EN adds a saturating count of full-FIFO stall edges on stall_cnt.
module q_4phase_rx #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic [WIDTH-1:0]         data,
  output logic                     ack,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
`ifdef Q4RX_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT_LO = 1'b1} state_t;

  state_t                 r_state;
  logic                   r_ack;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic [WIDTH-1:0]       r_mem [DEPTH];

  logic w_req_s;
  logic w_full;
  logic w_push;
  logic w_pop;

  // req is only ever seen through this chain; data is bundled and sampled raw.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= '0;
    else      r_sync <= {r_sync[SYNC_STAGES-2:0], req};
  end

  assign w_req_s   = r_sync[SYNC_STAGES-1];
  assign w_full    = (r_count == FULL);
  assign w_push    = (r_state == S_IDLE) && w_req_s && !w_full;
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign out_data  = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign ack       = r_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_ack    <= 1'b0;
      r_wr_ptr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_ack    <= 1'b1;
            r_state  <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (!w_req_s) begin
            r_ack   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data;
  end

  // Full test uses the registered count, so a pop never frees a slot for the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef Q4RX_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_stall_cnt <= '0;
    else if ((r_state == S_IDLE) && w_req_s && w_full && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_q_4phase_rx.sv
// Bench for q_4phase_rx: queue-based reference model checked every cycle, plus directed literals.
module tb_q_4phase_rx;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int SS    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic             out_ready = 1'b0;
  logic             ack;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       count;
`ifdef Q4RX_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  q_4phase_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .count(count)
`ifdef Q4RX_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: req delay line, a word queue and a handshake flag.
  bit               hist[$];
  logic [WIDTH-1:0] mq[$];
  bit               m_ack;
  int               m_stall;

  function automatic void model_clear();
    hist.delete();
    for (int i = 0; i < SS; i++) hist.push_back(1'b0);
    mq.delete();
    m_ack   = 1'b0;
    m_stall = 0;
  endfunction

  always @(negedge rst) model_clear();

  always @(posedge clk) begin
    bit reqs, pu, po;
    if (rst) begin
      reqs = hist[SS-1];
      po   = (mq.size() != 0) && out_ready;
      pu   = !m_ack && reqs && (mq.size() < DEPTH);
      if (!m_ack && reqs && (mq.size() == DEPTH) && m_stall < 65535) m_stall++;
      if (po) void'(mq.pop_front());
      if (pu) begin
        mq.push_back(data);
        m_ack = 1'b1;
      end else if (m_ack && !reqs) begin
        m_ack = 1'b0;
      end
      hist.push_front(req);
      void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("ack", ack, m_ack);
      chk("count", count, mq.size());
      chk("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) chk("out_data", out_data, mq[0]);
`ifdef Q4RX_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall);
`endif
    end
  end

  logic [WIDTH-1:0] pops[$];
  bit               mon_en = 1'b0;
  always @(posedge clk) if (rst && mon_en && out_valid && out_ready) pops.push_back(out_data);

  task automatic wait_ack(input logic v);
    int n = 0;
    while (ack !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ack_wait", ack, v);
  endtask

  task automatic hs(input logic [WIDTH-1:0] d);
    @(negedge clk);
    data = d;
    req  = 1'b1;
    wait_ack(1'b1);
    req = 1'b0;
    wait_ack(1'b0);
  endtask

  bit hs_done = 1'b0;
  bit rdone   = 1'b0;

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single transfer: ack rises on the 3rd edge, falls on the 3rd edge after req drops.
    data = 8'hA5; req = 1'b1;
    repeat (2) @(negedge clk);
    chk("t1_ack_e2", ack, 0);
    @(negedge clk);
    chk("t1_ack_e3", ack, 1);
    chk("t1_data", out_data, 8'hA5);
    chk("t1_count", count, 1);
    req = 1'b0;
    repeat (2) @(negedge clk);
    chk("t1_ackhi_e2", ack, 1);
    @(negedge clk);
    chk("t1_acklo_e3", ack, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Full backpressure.
    for (int i = 1; i <= 4; i++) hs(8'(i));
    chk("t2_full", count, 4);
    @(negedge clk);
    data = 8'h05; req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t2_hold_ack", ack, 0);
    end
    chk("t2_count4", count, 4);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t2_after_pop_count", count, 3);
    chk("t2_after_pop_head", out_data, 8'h02);
    chk("t2_no_same_edge_push", ack, 0);
    @(negedge clk);
    chk("t2_push_ack", ack, 1);
    chk("t2_push_count", count, 4);
    req = 1'b0;
    wait_ack(1'b0);
    for (int i = 2; i <= 5; i++) begin
      chk("t2_order", out_data, i);
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("t2_empty", count, 0);

    // Capture edge coincides with a pop.
    hs(8'h21);
    hs(8'h22);
    @(negedge clk);
    data = 8'h23; req = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t3_count", count, 2);
    chk("t3_ack", ack, 1);
    chk("t3_head", out_data, 8'h22);
    req = 1'b0;
    wait_ack(1'b0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;

    // Wrap-around with toggling out_ready.
    pops.delete();
    mon_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) hs(8'(16 + i));
        hs_done = 1'b1;
      end
      begin
        int n = 0;
        while ((!hs_done || count != 0) && n < 1000) begin
          @(negedge clk);
          out_ready = ~out_ready;
          n++;
        end
        out_ready = 1'b0;
      end
    join
    mon_en = 1'b0;
    chk("t4_npops", pops.size(), 10);
    for (int i = 0; i < 10 && i < pops.size(); i++) chk("t4_word", pops[i], 16 + i);
    chk("t4_count", count, 0);

    // Asynchronous reset in WAIT_LO.
    hs(8'h31);
    hs(8'h32);
    @(negedge clk);
    data = 8'h33; req = 1'b1;
    wait_ack(1'b1);
    chk("t5_count3", count, 3);
    @(posedge clk);
    #2;
    rst = 1'b0; req = 1'b0;
    #1;
    chk("t5_ack", ack, 0);
    chk("t5_valid", out_valid, 0);
    chk("t5_count", count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    hs(8'h3C);
    chk("t5_data", out_data, 8'h3C);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Random traffic against the model.
    fork
      begin
        repeat (40) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          hs(8'($urandom));
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 2) == 0);
        end
        out_ready = 1'b0;
      end
    join

`ifdef Q4RX_STALL_CNT_EN
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) hs(8'(8'h41 + i));
    @(negedge clk);
    data = 8'h45; req = 1'b1;
    repeat (2) @(negedge clk);
    chk("s_zero", stall_cnt, 0);
    repeat (7) @(negedge clk);
    chk("s_seven", stall_cnt, 7);
    repeat (70000) @(negedge clk);
    chk("s_sat", stall_cnt, 16'hFFFF);
    req = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
